// File: rtl/if_fetch_stage_if.sv
// Instruction-memory port: request/ready handshake with combinational address.
// The fetch stage is the master; the memory (or a bench model) is the slave.
interface if_fetch_stage_if #(
    parameter int unsigned ADDRESS_LEN     = 32,
    parameter int unsigned INSTRUCTION_LEN = 32
);
    logic                       req;
    logic [ADDRESS_LEN-1:0]     addr;
    logic                       ready;
    logic [INSTRUCTION_LEN-1:0] rdata;

    modport master (
        output req,
        output addr,
        input  ready,
        input  rdata
    );

    modport slave (
        input  req,
        input  addr,
        output ready,
        output rdata
    );
endinterface

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage and IF/ID pipeline register.
// Issues fetches on a variable-latency memory port and feeds decode one
// instruction per cycle when memory allows. A decode stall (freeze) holds
// IF/ID; a completed fetch during a stall is parked in a one-entry skid.
// An execute-stage redirect (branch_taken) squashes IF/ID and any parked
// or in-flight fetch. An in-flight fetch cannot be withdrawn without
// changing the address under a pending request, so it is drained in
// DISCARD and its data dropped.
module if_fetch_stage #(
    parameter int unsigned                ADDRESS_LEN     = 32,
    parameter int unsigned                INSTRUCTION_LEN = 32,
    parameter logic [ADDRESS_LEN-1:0]     RESET_PC        = 32'h0000_0000,
    parameter logic [INSTRUCTION_LEN-1:0] NOP_INSTR       = 32'hE1A0_0000
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       freeze,
    input  logic                       branch_taken,
    input  logic [ADDRESS_LEN-1:0]     branch_address,
    if_fetch_stage_if.master           imem,
    output logic [ADDRESS_LEN-1:0]     pc_out,
    output logic [INSTRUCTION_LEN-1:0] instruction_out,
    output logic                       valid_out
);

    typedef enum logic [1:0] {
        StFetch,
        StDiscard,
        StBuffered
    } state_e;

    state_e                     state_q, state_d;
    logic [ADDRESS_LEN-1:0]     pc_q, pc_d;
    logic [ADDRESS_LEN-1:0]     tgt_q, tgt_d;
    logic [ADDRESS_LEN-1:0]     skid_pc_q, skid_pc_d;
    logic [INSTRUCTION_LEN-1:0] skid_instr_q, skid_instr_d;
    logic [ADDRESS_LEN-1:0]     ifid_pc_q, ifid_pc_d;
    logic [INSTRUCTION_LEN-1:0] ifid_instr_q, ifid_instr_d;
    logic                       ifid_valid_q, ifid_valid_d;

    logic                       xfer;
    logic [ADDRESS_LEN-1:0]     pc_plus4;

    // Wraps modulo 2^ADDRESS_LEN; low bits are carried through untouched.
    assign pc_plus4 = pc_q + ADDRESS_LEN'(4);

    // Request is withdrawn only while a fetched word waits in the skid.
    assign imem.req  = (state_q != StBuffered);
    assign imem.addr = pc_q;
    // Ready without a request is not a transfer.
    assign xfer      = imem.req & imem.ready;

    assign pc_out          = ifid_pc_q;
    assign instruction_out = ifid_instr_q;
    assign valid_out       = ifid_valid_q;

    // Next-state: branch beats freeze beats normal flow.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        tgt_d        = tgt_q;
        skid_pc_d    = skid_pc_q;
        skid_instr_d = skid_instr_q;
        ifid_pc_d    = ifid_pc_q;
        ifid_instr_d = ifid_instr_q;
        ifid_valid_d = ifid_valid_q;

        if (branch_taken) begin
            // Bubble regardless of freeze; the skid is abandoned by leaving
            // BUFFERED.
            ifid_instr_d = NOP_INSTR;
            ifid_valid_d = 1'b0;
            if (state_q == StBuffered || imem.ready) begin
                pc_d    = branch_address;
                state_d = StFetch;
            end else begin
                // Keep the address stable; drain the pending fetch first.
                tgt_d   = branch_address;
                state_d = StDiscard;
            end
        end else if (freeze) begin
            unique case (state_q)
                StFetch: begin
                    if (imem.ready) begin
                        skid_pc_d    = pc_plus4;
                        skid_instr_d = imem.rdata;
                        pc_d         = pc_plus4;
                        state_d      = StBuffered;
                    end
                end
                StDiscard: begin
                    // IF/ID already holds a bubble; draining continues.
                    if (imem.ready) begin
                        pc_d    = tgt_q;
                        state_d = StFetch;
                    end
                end
                StBuffered: begin
                end
                default: begin
                    state_d = StFetch;
                end
            endcase
        end else begin
            unique case (state_q)
                StFetch: begin
                    if (imem.ready) begin
                        ifid_pc_d    = pc_plus4;
                        ifid_instr_d = imem.rdata;
                        ifid_valid_d = 1'b1;
                        pc_d         = pc_plus4;
                    end else begin
                        ifid_instr_d = NOP_INSTR;
                        ifid_valid_d = 1'b0;
                    end
                end
                StDiscard: begin
                    ifid_instr_d = NOP_INSTR;
                    ifid_valid_d = 1'b0;
                    if (imem.ready) begin
                        pc_d    = tgt_q;
                        state_d = StFetch;
                    end
                end
                StBuffered: begin
                    ifid_pc_d    = skid_pc_q;
                    ifid_instr_d = skid_instr_q;
                    ifid_valid_d = 1'b1;
                    state_d      = StFetch;
                end
                default: begin
                    state_d = StFetch;
                end
            endcase
        end
    end

    // Fetch control state: FSM, PC, redirect target.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StFetch;
            pc_q    <= RESET_PC;
            tgt_q   <= RESET_PC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            tgt_q   <= tgt_d;
        end
    end

    // Skid entry and IF/ID pipeline register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            skid_pc_q    <= '0;
            skid_instr_q <= '0;
            ifid_pc_q    <= '0;
            ifid_instr_q <= NOP_INSTR;
            ifid_valid_q <= 1'b0;
        end else begin
            skid_pc_q    <= skid_pc_d;
            skid_instr_q <= skid_instr_d;
            ifid_pc_q    <= ifid_pc_d;
            ifid_instr_q <= ifid_instr_d;
            ifid_valid_q <= ifid_valid_d;
        end
    end

    // xfer is kept as a named handshake term for debug visibility.
    logic unused_xfer;
    assign unused_xfer = xfer;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Bench for if_fetch_stage: memory model returns ROM[i]=i (rdata = addr>>2).
// Cycle-vector table for branch/freeze corners, scoreboard for streaming.
module tb_if_fetch_stage;

    localparam logic [31:0] NOP = 32'hE1A0_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        freeze;
    logic        branch_taken;
    logic [31:0] branch_address;
    logic        ready_drv;
    logic [31:0] pc_out;
    logic [31:0] instruction_out;
    logic        valid_out;

    int total = 0;
    int bad   = 0;

    if_fetch_stage_if #(.ADDRESS_LEN(32), .INSTRUCTION_LEN(32)) bus ();

    assign bus.ready = ready_drv;
    assign bus.rdata = bus.addr >> 2;

    if_fetch_stage dut (
        .clk             (clk),
        .rst             (rst),
        .freeze          (freeze),
        .branch_taken    (branch_taken),
        .branch_address  (branch_address),
        .imem            (bus),
        .pc_out          (pc_out),
        .instruction_out (instruction_out),
        .valid_out       (valid_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rdy;
        logic        frz;
        logic        br;
        logic [31:0] baddr;
        logic        ereq;
        logic [31:0] eaddr;
        logic [31:0] epc;
        logic [31:0] einstr;
        logic        evalid;
    } vec_t;

    logic [63:0] sbq[$];
    logic        prev_pend;
    logic [31:0] prev_addr;
    int          xfer_cnt;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic rdy, input logic frz, input logic br,
                                input logic [31:0] baddr, input logic ereq,
                                input logic [31:0] eaddr, input logic [31:0] epc,
                                input logic [31:0] einstr, input logic evalid);
        vec_t v;
        v.rdy = rdy; v.frz = frz; v.br = br; v.baddr = baddr; v.ereq = ereq;
        v.eaddr = eaddr; v.epc = epc; v.einstr = einstr; v.evalid = evalid;
        return v;
    endfunction

    // Starts and ends on a falling edge.
    task automatic do_reset();
        rst = 1'b1; freeze = 1'b0; branch_taken = 1'b0; branch_address = '0; ready_drv = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        sbq.delete();
        prev_pend = 1'b0;
        prev_addr = '0;
        xfer_cnt  = 0;
    endtask

    // One streaming cycle: push on transfer, pop when a new IF/ID value loads.
    task automatic sb_cycle(input logic rdy, input logic frz);
        logic        xf, pend;
        logic [31:0] a, hold_pc, hold_in;
        logic        hold_v;
        logic [63:0] e;
        ready_drv = rdy; freeze = frz; branch_taken = 1'b0;
        #2;
        a    = bus.addr;
        xf   = bus.req & bus.ready;
        pend = bus.req & ~bus.ready;
        if (prev_pend) chk("addr_stable", a, prev_addr);
        prev_pend = pend;
        prev_addr = a;
        hold_pc = pc_out; hold_in = instruction_out; hold_v = valid_out;
        if (xf) begin
            sbq.push_back({a + 32'd4, a >> 2});
            if (frz) xfer_cnt++;
        end
        @(posedge clk);
        #1;
        if (frz) begin
            chk("freeze_pc", pc_out, hold_pc);
            chk("freeze_instr", instruction_out, hold_in);
            chk("freeze_valid", {31'b0, valid_out}, {31'b0, hold_v});
        end else if (valid_out) begin
            if (sbq.size() == 0) begin
                chk("sb_unexpected_valid", {31'b0, valid_out}, 32'd0);
            end else begin
                e = sbq.pop_front();
                chk("sb_pc", pc_out, e[63:32]);
                chk("sb_instr", instruction_out, e[31:0]);
            end
        end else if (pend) begin
            chk("bubble_instr", instruction_out, NOP);
        end
        @(negedge clk);
    endtask

    initial begin
        vec_t vt[17];
        // Cycle table, checked before each rising edge.
        //          rdy  frz  br   baddr       req  addr        pc_out      instr   valid
        vt[0]  = mk(1'b0, 1'b0, 1'b0, 32'h0,   1'b1, 32'h0,   32'h0,   NOP,    1'b0);
        vt[1]  = mk(1'b1, 1'b0, 1'b0, 32'h0,   1'b1, 32'h0,   32'h0,   NOP,    1'b0);
        vt[2]  = mk(1'b1, 1'b0, 1'b0, 32'h0,   1'b1, 32'h4,   32'h4,   32'h0,  1'b1);
        vt[3]  = mk(1'b0, 1'b0, 1'b1, 32'h100, 1'b1, 32'h8,   32'h8,   32'h1,  1'b1);
        vt[4]  = mk(1'b0, 1'b0, 1'b0, 32'h0,   1'b1, 32'h8,   32'h8,   NOP,    1'b0);
        vt[5]  = mk(1'b1, 1'b0, 1'b0, 32'h0,   1'b1, 32'h8,   32'h8,   NOP,    1'b0);
        vt[6]  = mk(1'b1, 1'b0, 1'b0, 32'h0,   1'b1, 32'h100, 32'h8,   NOP,    1'b0);
        vt[7]  = mk(1'b1, 1'b1, 1'b0, 32'h0,   1'b1, 32'h104, 32'h104, 32'h40, 1'b1);
        vt[8]  = mk(1'b1, 1'b1, 1'b0, 32'h0,   1'b0, 32'h108, 32'h104, 32'h40, 1'b1);
        vt[9]  = mk(1'b0, 1'b1, 1'b1, 32'h200, 1'b0, 32'h108, 32'h104, 32'h40, 1'b1);
        vt[10] = mk(1'b1, 1'b0, 1'b0, 32'h0,   1'b1, 32'h200, 32'h104, NOP,    1'b0);
        vt[11] = mk(1'b0, 1'b0, 1'b0, 32'h0,   1'b1, 32'h204, 32'h204, 32'h80, 1'b1);
        vt[12] = mk(1'b0, 1'b0, 1'b1, 32'h300, 1'b1, 32'h204, 32'h204, NOP,    1'b0);
        vt[13] = mk(1'b0, 1'b0, 1'b1, 32'h400, 1'b1, 32'h204, 32'h204, NOP,    1'b0);
        vt[14] = mk(1'b1, 1'b0, 1'b0, 32'h0,   1'b1, 32'h204, 32'h204, NOP,    1'b0);
        vt[15] = mk(1'b1, 1'b0, 1'b0, 32'h0,   1'b1, 32'h400, 32'h204, NOP,    1'b0);
        vt[16] = mk(1'b0, 1'b0, 1'b0, 32'h0,   1'b1, 32'h404, 32'h404, 32'h100, 1'b1);

        rst = 1'b1; freeze = 1'b0; branch_taken = 1'b0; branch_address = '0; ready_drv = 1'b0;
        @(negedge clk);
        do_reset();
        chk("reset_pc_out", pc_out, 32'h0);
        chk("reset_instr", instruction_out, NOP);
        chk("reset_valid", {31'b0, valid_out}, 32'd0);

        for (int i = 0; i < 17; i++) begin
            ready_drv = vt[i].rdy; freeze = vt[i].frz;
            branch_taken = vt[i].br; branch_address = vt[i].baddr;
            #2;
            chk($sformatf("v%0d_req", i), {31'b0, bus.req}, {31'b0, vt[i].ereq});
            chk($sformatf("v%0d_addr", i), bus.addr, vt[i].eaddr);
            chk($sformatf("v%0d_pc", i), pc_out, vt[i].epc);
            chk($sformatf("v%0d_instr", i), instruction_out, vt[i].einstr);
            chk($sformatf("v%0d_valid", i), {31'b0, valid_out}, {31'b0, vt[i].evalid});
            @(negedge clk);
        end

        // Reset in the middle of DISCARD: stale target must never be used.
        ready_drv = 1'b0; freeze = 1'b0; branch_taken = 1'b1; branch_address = 32'h500;
        @(negedge clk);
        branch_taken = 1'b0; branch_address = '0;
        #2 rst = 1'b1;
        #1;
        chk("arst_valid", {31'b0, valid_out}, 32'd0);
        chk("arst_instr", instruction_out, NOP);
        chk("arst_pc_out", pc_out, 32'h0);
        chk("arst_addr", bus.addr, 32'h0);
        chk("arst_req", {31'b0, bus.req}, 32'd1);
        @(negedge clk);
        rst = 1'b0; ready_drv = 1'b1;
        #2 chk("post_rst_addr", bus.addr, 32'h0);
        @(posedge clk);
        #1;
        chk("post_rst_instr", instruction_out, 32'h0);
        chk("post_rst_pc", pc_out, 32'h4);
        chk("post_rst_valid", {31'b0, valid_out}, 32'd1);
        @(negedge clk);
        ready_drv = 1'b0;
        #2 chk("post_rst_next_addr", bus.addr, 32'h4);
        @(negedge clk);

        // Zero-wait streaming.
        do_reset();
        for (int i = 0; i < 20; i++) sb_cycle(1'b1, 1'b0);
        chk("stream_drained", sbq.size(), 32'd0);
        chk("stream_last_pc", pc_out, 32'd80);

        // Ready every third cycle.
        do_reset();
        for (int i = 0; i < 30; i++) sb_cycle((i % 3) == 2, 1'b0);
        chk("slow_drained", sbq.size(), 32'd0);
        chk("slow_last_pc", pc_out, 32'd40);

        // Freeze for four cycles under zero-wait memory.
        do_reset();
        for (int i = 0; i < 3; i++) sb_cycle(1'b1, 1'b0);
        for (int i = 0; i < 4; i++) sb_cycle(1'b1, 1'b1);
        chk("skid_captures", xfer_cnt, 32'd1);
        for (int i = 0; i < 5; i++) sb_cycle(1'b1, 1'b0);
        chk("freeze_drained", sbq.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
